// File: rtl/step_enable_ctrl_if.sv
// step_enable_ctrl_if: event sources, mode/stall controls and step outputs of the step-enable controller
interface step_enable_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             tick_i;
  logic             btn_i;
  logic [1:0]       mode_i;
  logic             hold_i;
  logic             step_en_o;
  logic [CNT_W-1:0] step_count_o;
  logic             dropped_o;
  modport master (
    output tick_i, btn_i, mode_i, hold_i,
    input  step_en_o, step_count_o, dropped_o
  );
  modport slave (
    input  tick_i, btn_i, mode_i, hold_i,
    output step_en_o, step_count_o, dropped_o
  );
endinterface

// File: rtl/step_enable_ctrl.sv
// step_enable_ctrl: turns slow-clock ticks or debounced button presses into single-cycle core step enables
module step_enable_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BOTH_EDGES      = 1,
  parameter int CNT_W           = 32
) (
  input logic              clk_i,
  input logic              rst_i,
  step_enable_ctrl_if.slave bus
);
  localparam int DW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [1:0] M_HALT = 2'b00;
  localparam logic [1:0] M_AUTO = 2'b01;
  localparam logic [1:0] M_MAN  = 2'b10;
  localparam logic [1:0] M_FREE = 2'b11;
  logic             tick_s1, tick_s2, tick_prev;
  logic             btn_s1, btn_s2, btn_db, btn_db_prev;
  logic [DW-1:0]    db_cnt;
  logic             tick_ev, btn_ev, req;
  logic             pending, step_en, dropped;
  logic [CNT_W-1:0] count;
  // two-flop synchronisers plus previous-level registers for edge detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_s1     <= 1'b0;
      tick_s2     <= 1'b0;
      tick_prev   <= 1'b0;
      btn_s1      <= 1'b0;
      btn_s2      <= 1'b0;
      btn_db_prev <= 1'b0;
    end else begin
      tick_s1     <= bus.tick_i;
      tick_s2     <= tick_s1;
      tick_prev   <= tick_s2;
      btn_s1      <= bus.btn_i;
      btn_s2      <= btn_s1;
      btn_db_prev <= btn_db;
    end
  end
  // debounced level flips only after the synced button differs for DEBOUNCE_CYCLES cycles in a row
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
  // only the source chosen by the mode may raise a request
  always_comb begin
    tick_ev = (BOTH_EDGES != 0) ? (tick_s2 ^ tick_prev) : (tick_s2 & ~tick_prev);
    btn_ev  = btn_db & ~btn_db_prev;
    req     = (bus.mode_i == M_AUTO) ? tick_ev :
              (bus.mode_i == M_MAN)  ? btn_ev  : 1'b0;
  end
  // issue steps, park one request while stalled, flag overflow and count issued steps
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      step_en <= 1'b0;
      pending <= 1'b0;
      dropped <= 1'b0;
      count   <= '0;
    end else begin
      count <= count + CNT_W'(step_en);
      if (bus.mode_i == M_FREE) begin
        step_en <= ~bus.hold_i;
        pending <= 1'b0;
      end else if (bus.mode_i == M_HALT) begin
        step_en <= 1'b0;
        pending <= 1'b0;
      end else begin
        step_en <= ~bus.hold_i & (req | pending);
        if (bus.hold_i && req) begin
          pending <= 1'b1;
          if (pending) dropped <= 1'b1;
        end else if (!bus.hold_i) begin
          pending <= 1'b0;
        end
      end
    end
  end
  assign bus.step_en_o    = step_en;
  assign bus.step_count_o = count;
  assign bus.dropped_o    = dropped;
endmodule

// File: tb/tb_step_enable_ctrl.sv
// tb_step_enable_ctrl: scoreboard bench predicting the cycle of every step pulse and the step count
module tb_step_enable_ctrl;
  localparam int DB = 4;
  localparam int CW = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic       hold = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [1:0] mode_b = 2'b00;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_a = 0;
  int exp_b = 0;
  int ea, eb;
  int qa[$];
  int qb[$];
  step_enable_ctrl_if #(.CNT_W(CW)) bus_a ();
  step_enable_ctrl_if #(.CNT_W(CW)) bus_b ();
  assign bus_a.tick_i = tick;
  assign bus_a.btn_i  = btn;
  assign bus_a.mode_i = mode;
  assign bus_a.hold_i = hold;
  assign bus_b.tick_i = tick;
  assign bus_b.btn_i  = btn;
  assign bus_b.mode_i = mode_b;
  assign bus_b.hold_i = hold;
  step_enable_ctrl #(.DEBOUNCE_CYCLES(DB), .BOTH_EDGES(1), .CNT_W(CW)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );
  step_enable_ctrl #(.DEBOUNCE_CYCLES(DB), .BOTH_EDGES(0), .CNT_W(CW)) u_dut_re (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (qa.size() > 0 && qa[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL pulse_a_missed: expected step_en at cycle %0d, none by cycle %0d", qa[0], cyc);
        void'(qa.pop_front());
      end
      if (qb.size() > 0 && qb[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL pulse_b_missed: expected step_en at cycle %0d, none by cycle %0d", qb[0], cyc);
        void'(qb.pop_front());
      end
      if (bus_a.step_en_o) begin
        checks++;
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL pulse_a_unexpected: step_en=1 at cycle %0d, expected 0", cyc);
        end else begin
          ea = qa.pop_front();
          if (ea != cyc) begin
            errors++;
            $display("FAIL pulse_a_time: pulse at cycle %0d, expected cycle %0d", cyc, ea);
          end
        end
      end
      if (bus_b.step_en_o) begin
        checks++;
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL pulse_b_unexpected: step_en=1 at cycle %0d, expected 0", cyc);
        end else begin
          eb = qb.pop_front();
          if (eb != cyc) begin
            errors++;
            $display("FAIL pulse_b_time: pulse at cycle %0d, expected cycle %0d", cyc, eb);
          end
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check_idle_a(input string name);
    checks++;
    if (qa.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d expected pulses never seen, required 0", name, qa.size());
    end
    checks++;
    if (bus_a.step_count_o !== CW'(exp_a)) begin
      errors++;
      $display("FAIL %s_count: step_count=%0d, expected %0d", name, bus_a.step_count_o, CW'(exp_a));
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step(3);
    checks++;
    if (bus_a.step_en_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_step_en: got %b, expected 0", bus_a.step_en_o);
    end
    checks++;
    if (bus_a.step_count_o !== '0) begin
      errors++;
      $display("FAIL reset_count: got %0d, expected 0", bus_a.step_count_o);
    end
    checks++;
    if (bus_a.dropped_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_dropped: got %b, expected 0", bus_a.dropped_o);
    end
    checks++;
    if (bus_b.step_en_o !== 1'b0 || bus_b.step_count_o !== '0) begin
      errors++;
      $display("FAIL reset_b: step_en=%b count=%0d, expected 0 0", bus_b.step_en_o, bus_b.step_count_o);
    end
    rst = 1'b0;
    step(2);
  endtask
  task automatic test_auto();
    mode   = 2'b01;
    mode_b = 2'b01;
    step(5);
    for (int i = 0; i < 4; i++) begin
      tick = ~tick;
      qa.push_back(cyc + 3);
      exp_a++;
      if (tick) begin
        qb.push_back(cyc + 3);
        exp_b++;
      end
      step(20);
    end
    check_idle_a("auto");
    checks++;
    if (qb.size() != 0 || bus_b.step_count_o !== CW'(exp_b)) begin
      errors++;
      $display("FAIL auto_rising_count: count=%0d left=%0d, expected %0d left=0", bus_b.step_count_o, qb.size(), exp_b);
    end
    mode_b = 2'b00;
    step(2);
  endtask
  task automatic test_manual();
    mode = 2'b10;
    step(3);
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    btn = 1'b1; step(1);
    btn = 1'b0; step(1);
    btn = 1'b1;
    qa.push_back(cyc + 7);
    exp_a++;
    step(10);
    btn = 1'b0;
    step(12);
    btn = 1'b1;
    qa.push_back(cyc + 7);
    exp_a++;
    step(10);
    btn = 1'b0;
    step(12);
    check_idle_a("manual");
  endtask
  task automatic test_hold();
    mode = 2'b01;
    hold = 1'b1;
    step(2);
    tick = ~tick;
    step(10);
    checks++;
    if (bus_a.dropped_o !== 1'b0) begin
      errors++;
      $display("FAIL hold_single_dropped: got %b, expected 0", bus_a.dropped_o);
    end
    hold = 1'b0;
    qa.push_back(cyc + 1);
    exp_a++;
    step(5);
    hold = 1'b1;
    tick = ~tick;
    step(5);
    tick = ~tick;
    step(10);
    hold = 1'b0;
    qa.push_back(cyc + 1);
    exp_a++;
    step(5);
    checks++;
    if (bus_a.dropped_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_double_dropped: got %b, expected 1", bus_a.dropped_o);
    end
    check_idle_a("hold");
  endtask
  task automatic test_free_halt();
    mode = 2'b11;
    hold = 1'b0;
    for (int i = 1; i <= 5; i++) qa.push_back(cyc + i);
    exp_a += 5;
    step(5);
    hold = 1'b1;
    step(2);
    mode = 2'b00;
    hold = 1'b0;
    step(2);
    tick = ~tick;
    step(6);
    tick = ~tick;
    step(10);
    check_idle_a("free_halt");
    checks++;
    if (bus_a.dropped_o !== 1'b1) begin
      errors++;
      $display("FAIL dropped_sticky: got %b, expected 1", bus_a.dropped_o);
    end
  endtask
  task automatic test_reset_mid_debounce();
    mode = 2'b10;
    btn = 1'b1;
    step(4);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    exp_a = 0;
    exp_b = 0;
    step(1);
    checks++;
    if (bus_a.step_en_o !== 1'b0 || bus_a.step_count_o !== '0 || bus_a.dropped_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: step_en=%b count=%0d dropped=%b, expected 0 0 0", bus_a.step_en_o, bus_a.step_count_o, bus_a.dropped_o);
    end
    rst = 1'b0;
    qa.push_back(cyc + 7);
    exp_a++;
    step(12);
    btn = 1'b0;
    step(12);
    check_idle_a("midreset");
  endtask
  task automatic test_wrap();
    mode = 2'b00;
    rst = 1'b1;
    qa.delete();
    exp_a = 0;
    step(1);
    rst = 1'b0;
    step(2);
    mode = 2'b11;
    hold = 1'b0;
    for (int i = 1; i <= 15; i++) qa.push_back(cyc + i);
    exp_a += 15;
    step(15);
    hold = 1'b1;
    step(3);
    checks++;
    if (bus_a.step_count_o !== 4'hF) begin
      errors++;
      $display("FAIL wrap_all_ones: count=%0d, expected 15", bus_a.step_count_o);
    end
    hold = 1'b0;
    qa.push_back(cyc + 1);
    exp_a++;
    step(1);
    hold = 1'b1;
    step(3);
    check_idle_a("wrap");
    mode = 2'b00;
    hold = 1'b0;
    step(2);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_auto();
    test_manual();
    test_hold();
    test_free_halt();
    test_reset_mid_debounce();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
